// File: rtl/picomips_pkg.sv
// rtl/picomips_pkg.sv - shared picoMIPS types, opcode constants and default widths
package picomips_pkg;

    localparam int PC_WIDTH_DEF     = 8;
    localparam int INSTR_WIDTH_DEF  = 20;
    localparam int OPCODE_WIDTH_DEF = 6;

    // Opcode the decoder treats as "do nothing"; driven whenever the fetch slot is empty.
    localparam logic [OPCODE_WIDTH_DEF-1:0] OP_NOP = 6'b000000;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_target.sv
// rtl/pc_target.sv - branch target selection with modulo address arithmetic
module pc_target
    import picomips_pkg::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic                abs_branch,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic [PC_WIDTH-1:0] branch_offset,
    output logic [PC_WIDTH-1:0] target
);

    // Absolute wins when both requests are present; relative offset is taken from the
    // branching instruction's own pc and wraps naturally at PC_WIDTH bits.
    always_comb begin
        target = abs_branch ? branch_target : (pc + branch_offset);
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - picoMIPS instruction fetch stage with one-slot branch squash
module fetch_unit
    import picomips_pkg::*;
#(
    parameter int PC_WIDTH     = PC_WIDTH_DEF,
    parameter int INSTR_WIDTH  = INSTR_WIDTH_DEF,
    parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    stall,
    input  logic                    PC_abs_branch,
    input  logic                    PC_rel_branch,
    input  logic                    PC_incr,
    input  logic [PC_WIDTH-1:0]     branch_target,
    input  logic [PC_WIDTH-1:0]     branch_offset,
    output logic [PC_WIDTH-1:0]     imem_addr,
    output logic                    imem_en,
    input  logic [INSTR_WIDTH-1:0]  imem_rdata,
    output logic [INSTR_WIDTH-1:0]  instr,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    instr_valid,
    output logic [PC_WIDTH-1:0]     pc
);

    fetch_state_t        state, state_next;
    logic [PC_WIDTH-1:0] fetch_q, fetch_next;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] target;
    logic                redirect;
    logic                unused_incr;

    // The decoder's sequential hint carries no information we need.
    assign unused_incr = PC_incr;

    pc_target #(.PC_WIDTH(PC_WIDTH)) u_pc_target (
        .abs_branch    (PC_abs_branch),
        .pc            (pc_q),
        .branch_target (branch_target),
        .branch_offset (branch_offset),
        .target        (target)
    );

    // Only a real instruction may redirect; squashed/fill slots ignore decoder controls.
    assign redirect = (state == RUN) & ~stall & (PC_abs_branch | PC_rel_branch);

    // State and address registers; stall freezes everything, reset overrides stall.
    always_ff @(posedge clk) begin
        if (!nReset) begin
            state   <= FILL;
            fetch_q <= '0;
            pc_q    <= '0;
        end else if (!stall) begin
            state   <= state_next;
            fetch_q <= fetch_next;
            pc_q    <= fetch_q;
        end
    end

    // Next-state and next fetch address selection.
    always_comb begin
        state_next = state;
        fetch_next = fetch_q + 1'b1;
        case (state)
            FILL:    state_next = RUN;
            RUN: begin
                if (redirect) begin
                    state_next = FLUSH;
                    fetch_next = target;
                end
            end
            FLUSH:   state_next = RUN;
            default: state_next = FILL;
        endcase
    end

    // Decoder-facing outputs; an empty slot presents zero data and the NOP opcode.
    always_comb begin
        instr_valid = (state == RUN);
        instr       = '0;
        opcode      = OPCODE_WIDTH'(OP_NOP);
        if (instr_valid) begin
            instr  = imem_rdata;
            opcode = imem_rdata[INSTR_WIDTH-1 -: OPCODE_WIDTH];
        end
    end

    assign imem_addr = fetch_q;
    assign imem_en   = ~stall;
    assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a next-pc reference model
module tb_fetch_unit;

    localparam logic [5:0] NOP = 6'h00;

    logic        clk = 1'b0;
    logic        nReset;
    logic        stall;
    logic        PC_abs_branch;
    logic        PC_rel_branch;
    logic        PC_incr;
    logic [7:0]  branch_target;
    logic [7:0]  branch_offset;
    logic [7:0]  imem_addr;
    logic        imem_en;
    logic [19:0] imem_rdata;
    logic [19:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [7:0]  pc;

    logic [19:0] mem [256];

    int errors = 0;
    int checks = 0;

    // Reference model: whether a real instruction is showing, its address,
    // and the address of the next instruction to be shown.
    bit          m_valid;
    bit          m_pc_known;
    logic [7:0]  m_pc;
    logic [7:0]  m_next;

    fetch_unit dut (
        .clk           (clk),
        .nReset        (nReset),
        .stall         (stall),
        .PC_abs_branch (PC_abs_branch),
        .PC_rel_branch (PC_rel_branch),
        .PC_incr       (PC_incr),
        .branch_target (branch_target),
        .branch_offset (branch_offset),
        .imem_addr     (imem_addr),
        .imem_en       (imem_en),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .pc            (pc)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory that holds its output while disabled.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        logic [19:0] word;
        @(posedge clk);
        if (!nReset) begin
            m_valid = 1'b0; m_next = 8'd0; m_pc = 8'd0; m_pc_known = 1'b1;
        end else if (!stall) begin
            if (m_valid && (PC_abs_branch || PC_rel_branch)) begin
                m_next     = PC_abs_branch ? branch_target : 8'(m_pc + branch_offset);
                m_valid    = 1'b0;
                m_pc_known = 1'b0;
            end else begin
                m_valid    = 1'b1;
                m_pc       = m_next;
                m_next     = m_next + 8'd1;
                m_pc_known = 1'b1;
            end
        end
        #1;
        word = mem[m_pc];
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("imem_addr", 32'(imem_addr), 32'(m_next));
        check("imem_en", 32'(imem_en), 32'(!stall));
        check("instr", 32'(instr), m_valid ? 32'(word) : 32'd0);
        check("opcode", 32'(opcode), m_valid ? 32'(word[19:14]) : 32'(NOP));
        if (m_pc_known) check("pc", 32'(pc), 32'(m_pc));
    endtask

    task automatic clear_branch();
        PC_abs_branch = 1'b0; PC_rel_branch = 1'b0;
    endtask

    task automatic run_until(input logic [7:0] p);
        bit found = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (m_valid && m_pc == p) begin found = 1'b1; break; end
            step();
        end
        if (!found) check("run_until_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 20'(i * 3);
            if (i >= 16) mem[i][19:14] = 6'($urandom_range(0, 63));
        end
        nReset = 1'b0; stall = 1'b0; PC_incr = 1'b1;
        clear_branch(); branch_target = '0; branch_offset = '0;
        m_valid = 1'b0; m_pc_known = 1'b0; m_pc = '0; m_next = '0;

        // Reset and fill
        step(); step();
        nReset = 1'b1;
        step(); step(); step();

        // Relative branch back by 3 from pc=5
        run_until(8'd5);
        PC_rel_branch = 1'b1; branch_offset = 8'hFD;
        step(); clear_branch();
        check("rel_bubble", 32'(instr_valid), 32'd0);
        step();
        check("rel_target_pc", 32'(pc), 32'd2);

        // Stall at pc=4 with a branch request arriving mid-stall
        run_until(8'd4);
        stall = 1'b1;
        step();
        PC_abs_branch = 1'b1; branch_target = 8'd99;
        step(); step();
        stall = 1'b0; clear_branch();
        step();
        check("stall_resume_pc", 32'(pc), 32'd5);

        // Absolute branch, then both requests together
        run_until(8'd7);
        PC_abs_branch = 1'b1; branch_target = 8'd40;
        step(); clear_branch();
        step();
        check("abs_target_pc", 32'(pc), 32'd40);
        step();
        PC_abs_branch = 1'b1; PC_rel_branch = 1'b1;
        branch_target = 8'd100; branch_offset = 8'd5;
        step(); clear_branch();
        step();
        check("abs_wins_pc", 32'(pc), 32'd100);

        // Wrap-around, then a branch presented during the squash slot
        PC_abs_branch = 1'b1; branch_target = 8'd254;
        step(); clear_branch();
        run_until(8'd255);
        step();
        check("wrap_pc", 32'(pc), 32'd0);
        run_until(8'd1);
        PC_abs_branch = 1'b1; branch_target = 8'd50;
        step();
        branch_target = 8'd200;
        step(); clear_branch();
        step();
        check("flush_branch_ignored_pc", 32'(pc), 32'd51);

        // Reset during FLUSH while stalled
        PC_rel_branch = 1'b1; branch_offset = 8'd10;
        step(); clear_branch();
        nReset = 1'b0; stall = 1'b1;
        step();
        check("midreset_addr", 32'(imem_addr), 32'd0);
        nReset = 1'b1; stall = 1'b0;
        step(); step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            stall         = ($urandom_range(0, 3) == 0);
            PC_abs_branch = ($urandom_range(0, 4) == 0);
            PC_rel_branch = ($urandom_range(0, 4) == 0);
            PC_incr       = 1'($urandom);
            branch_target = 8'($urandom);
            branch_offset = 8'($urandom);
            nReset        = ($urandom_range(0, 49) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
